// File: rtl/pulse_stream_capture.sv
// rtl/pulse_stream_capture.sv - captures one serial frame and reports pattern, ones, rises and longest run
module pulse_stream_capture #(
    parameter int WIDTH       = 16,
    parameter int START_DELAY = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       pulse_in,
    output logic                       busy,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [WIDTH-1:0]           pattern,
    output logic [$clog2(WIDTH+1)-1:0] ones_count,
    output logic [$clog2(WIDTH+1)-1:0] rise_count,
    output logic [$clog2(WIDTH+1)-1:0] max_run
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = $clog2(WIDTH);
    localparam int DW = $clog2(START_DELAY + 2);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DONE} state_t;

    state_t           state_q;
    logic [DW-1:0]    dly_q;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] pattern_q;
    logic [CW-1:0]    ones_q;
    logic [CW-1:0]    rise_q;
    logic [CW-1:0]    run_q;
    logic [CW-1:0]    max_q;
    logic             busy_q;
    logic             valid_q;

    logic [CW-1:0]    run_d;
    logic [CW-1:0]    max_d;

    always_comb begin
        run_d = pulse_in ? run_q + CW'(1) : '0;
        max_d = (run_d > max_q) ? run_d : max_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dly_q     <= '0;
            bit_q     <= '0;
            pattern_q <= '0;
            ones_q    <= '0;
            rise_q    <= '0;
            run_q     <= '0;
            max_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ones_q <= '0;
                        rise_q <= '0;
                        run_q  <= '0;
                        max_q  <= '0;
                        bit_q  <= '0;
                        busy_q <= 1'b1;
                        if (START_DELAY == 0) begin
                            state_q <= CAPTURE;
                        end else begin
                            state_q <= WAIT;
                            dly_q   <= DW'(START_DELAY);
                        end
                    end
                end
                WAIT: begin
                    dly_q <= dly_q - DW'(1);
                    if (dly_q == DW'(1)) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    pattern_q <= {pattern_q[WIDTH-2:0], pulse_in};
                    ones_q    <= ones_q + {{(CW-1){1'b0}}, pulse_in};
                    // The first sample has no predecessor inside the frame, so it never counts as a rise.
                    if (pulse_in && !pattern_q[0] && (bit_q != '0)) begin
                        rise_q <= rise_q + CW'(1);
                    end
                    run_q <= run_d;
                    max_q <= max_d;
                    bit_q <= bit_q + BW'(1);
                    if (bit_q == BW'(WIDTH - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    // valid rises one edge after entry; the handshake only counts once it is visible.
                    if (valid_q && result_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign pattern      = pattern_q;
    assign ones_count   = ones_q;
    assign rise_count   = rise_q;
    assign max_run      = max_q;

endmodule

// File: tb/tb_pulse_stream_capture.sv
// tb/tb_pulse_stream_capture.sv - directed self-checking bench for pulse_stream_capture
module tb_pulse_stream_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        pulse = 1'b0;
    logic        ready = 1'b0;

    logic        busy_a, valid_a, busy_b, valid_b;
    logic [15:0] pat_a, pat_b;
    logic [4:0]  ones_a, rise_a, max_a, ones_b, rise_b, max_b;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pulse_stream_capture #(.WIDTH(16), .START_DELAY(1)) dut_a (
        .clock(clk), .reset(rst), .start(start_a), .pulse_in(pulse),
        .busy(busy_a), .result_valid(valid_a), .result_ready(ready),
        .pattern(pat_a), .ones_count(ones_a), .rise_count(rise_a), .max_run(max_a)
    );

    pulse_stream_capture #(.WIDTH(16), .START_DELAY(0)) dut_b (
        .clock(clk), .reset(rst), .start(start_b), .pulse_in(pulse),
        .busy(busy_b), .result_valid(valid_b), .result_ready(ready),
        .pattern(pat_b), .ones_count(ones_b), .rise_count(rise_b), .max_run(max_b)
    );

    task automatic capture(input logic [15:0] v, input bit use_b,
                           output logic early, output logic late);
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        pulse = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        if (!use_b) @(negedge clk);
        for (int i = 15; i >= 0; i--) begin
            pulse = v[i];
            @(negedge clk);
        end
        pulse = 1'b0;
        early = use_b ? valid_b : valid_a;
        @(negedge clk);
        late = use_b ? valid_b : valid_a;
    endtask

    task automatic handshake();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        compared += 6;
        if (busy_a !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy_a); end
        if (valid_a !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", valid_a); end
        if (pat_a !== 16'h0) begin mismatched++; $display("FAIL reset_pattern got %h want 0000", pat_a); end
        if (ones_a !== 5'd0) begin mismatched++; $display("FAIL reset_ones got %0d want 0", ones_a); end
        if (rise_a !== 5'd0) begin mismatched++; $display("FAIL reset_rise got %0d want 0", rise_a); end
        if (max_a !== 5'd0) begin mismatched++; $display("FAIL reset_max got %0d want 0", max_a); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_a5f0();
        logic e, l;
        capture(16'hA5F0, 1'b0, e, l);
        compared += 7;
        if (e !== 1'b0) begin mismatched++; $display("FAIL a5f0_valid_k17 got %b want 0", e); end
        if (l !== 1'b1) begin mismatched++; $display("FAIL a5f0_valid_k18 got %b want 1", l); end
        if (busy_a !== 1'b0) begin mismatched++; $display("FAIL a5f0_busy got %b want 0", busy_a); end
        if (pat_a !== 16'hA5F0) begin mismatched++; $display("FAIL a5f0_pattern got %h want a5f0", pat_a); end
        if (ones_a !== 5'd8) begin mismatched++; $display("FAIL a5f0_ones got %0d want 8", ones_a); end
        if (rise_a !== 5'd3) begin mismatched++; $display("FAIL a5f0_rise got %0d want 3", rise_a); end
        if (max_a !== 5'd5) begin mismatched++; $display("FAIL a5f0_max got %0d want 5", max_a); end
        handshake();
        compared += 2;
        if (valid_a !== 1'b0) begin mismatched++; $display("FAIL a5f0_valid_after_hs got %b want 0", valid_a); end
        if (pat_a !== 16'hA5F0) begin mismatched++; $display("FAIL a5f0_hold_after_hs got %h want a5f0", pat_a); end
    endtask

    task automatic test_full_ones();
        logic e, l;
        capture(16'hFFFF, 1'b0, e, l);
        compared += 5;
        if (l !== 1'b1) begin mismatched++; $display("FAIL ffff_valid got %b want 1", l); end
        if (pat_a !== 16'hFFFF) begin mismatched++; $display("FAIL ffff_pattern got %h want ffff", pat_a); end
        if (ones_a !== 5'd16) begin mismatched++; $display("FAIL ffff_ones got %0d want 16", ones_a); end
        if (rise_a !== 5'd0) begin mismatched++; $display("FAIL ffff_rise got %0d want 0", rise_a); end
        if (max_a !== 5'd16) begin mismatched++; $display("FAIL ffff_max got %0d want 16", max_a); end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic e, l;
        capture(16'h0000, 1'b0, e, l);
        compared += 5;
        if (l !== 1'b1) begin mismatched++; $display("FAIL zero_valid got %b want 1", l); end
        if (pat_a !== 16'h0000) begin mismatched++; $display("FAIL zero_pattern got %h want 0000", pat_a); end
        if (ones_a !== 5'd0) begin mismatched++; $display("FAIL zero_ones got %0d want 0", ones_a); end
        if (rise_a !== 5'd0) begin mismatched++; $display("FAIL zero_rise got %0d want 0", rise_a); end
        if (max_a !== 5'd0) begin mismatched++; $display("FAIL zero_max got %0d want 0", max_a); end
        handshake();
        capture(16'h5555, 1'b0, e, l);
        compared += 5;
        if (l !== 1'b1) begin mismatched++; $display("FAIL 5555_valid got %b want 1", l); end
        if (pat_a !== 16'h5555) begin mismatched++; $display("FAIL 5555_pattern got %h want 5555", pat_a); end
        if (ones_a !== 5'd8) begin mismatched++; $display("FAIL 5555_ones got %0d want 8", ones_a); end
        if (rise_a !== 5'd8) begin mismatched++; $display("FAIL 5555_rise got %0d want 8", rise_a); end
        if (max_a !== 5'd1) begin mismatched++; $display("FAIL 5555_max got %0d want 1", max_a); end
        handshake();
    endtask

    task automatic test_hold_ready();
        logic e, l;
        capture(16'h3C3C, 1'b0, e, l);
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start_a = (i == 4);
            @(negedge clk);
            compared += 3;
            if (valid_a !== 1'b1) begin mismatched++; $display("FAIL hold_valid cycle %0d got %b want 1", i, valid_a); end
            if (pat_a !== 16'h3C3C) begin mismatched++; $display("FAIL hold_pattern cycle %0d got %h want 3c3c", i, pat_a); end
            if (max_a !== 5'd4) begin mismatched++; $display("FAIL hold_max cycle %0d got %0d want 4", i, max_a); end
        end
        start_a = 1'b0;
        compared += 1;
        if (busy_a !== 1'b0) begin mismatched++; $display("FAIL hold_start_ignored busy got %b want 0", busy_a); end
        start_a = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        ready = 1'b0;
        compared += 2;
        if (valid_a !== 1'b0) begin mismatched++; $display("FAIL hs_with_start_valid got %b want 0", valid_a); end
        if (busy_a !== 1'b0) begin mismatched++; $display("FAIL hs_with_start_dropped busy got %b want 0", busy_a); end
        @(negedge clk);
        compared += 1;
        if (busy_a !== 1'b0) begin mismatched++; $display("FAIL hs_start_still_idle busy got %b want 0", busy_a); end
    endtask

    task automatic test_reset_mid();
        logic e, l;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            pulse = 1'b1;
            @(negedge clk);
        end
        pulse = 1'b0;
        compared += 2;
        if (busy_a !== 1'b1) begin mismatched++; $display("FAIL mid_busy got %b want 1", busy_a); end
        if (pat_a[6:0] !== 7'h7F) begin mismatched++; $display("FAIL mid_partial got %h want 7f", pat_a[6:0]); end
        #2 rst = 1'b1;
        #1;
        compared += 6;
        if (busy_a !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy got %b want 0", busy_a); end
        if (valid_a !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid got %b want 0", valid_a); end
        if (pat_a !== 16'h0) begin mismatched++; $display("FAIL rstmid_pattern got %h want 0000", pat_a); end
        if (ones_a !== 5'd0) begin mismatched++; $display("FAIL rstmid_ones got %0d want 0", ones_a); end
        if (rise_a !== 5'd0) begin mismatched++; $display("FAIL rstmid_rise got %0d want 0", rise_a); end
        if (max_a !== 5'd0) begin mismatched++; $display("FAIL rstmid_max got %0d want 0", max_a); end
        @(negedge clk);
        rst = 1'b0;
        capture(16'h8001, 1'b0, e, l);
        compared += 5;
        if (l !== 1'b1) begin mismatched++; $display("FAIL 8001_valid got %b want 1", l); end
        if (pat_a !== 16'h8001) begin mismatched++; $display("FAIL 8001_pattern got %h want 8001", pat_a); end
        if (ones_a !== 5'd2) begin mismatched++; $display("FAIL 8001_ones got %0d want 2", ones_a); end
        if (rise_a !== 5'd1) begin mismatched++; $display("FAIL 8001_rise got %0d want 1", rise_a); end
        if (max_a !== 5'd1) begin mismatched++; $display("FAIL 8001_max got %0d want 1", max_a); end
        handshake();
    endtask

    task automatic test_zero_delay();
        logic e, l;
        capture(16'hC003, 1'b1, e, l);
        compared += 6;
        if (e !== 1'b0) begin mismatched++; $display("FAIL c003_valid_k16 got %b want 0", e); end
        if (l !== 1'b1) begin mismatched++; $display("FAIL c003_valid_k17 got %b want 1", l); end
        if (pat_b !== 16'hC003) begin mismatched++; $display("FAIL c003_pattern got %h want c003", pat_b); end
        if (ones_b !== 5'd4) begin mismatched++; $display("FAIL c003_ones got %0d want 4", ones_b); end
        if (rise_b !== 5'd1) begin mismatched++; $display("FAIL c003_rise got %0d want 1", rise_b); end
        if (max_b !== 5'd2) begin mismatched++; $display("FAIL c003_max got %0d want 2", max_b); end
        handshake();
        compared += 1;
        if (valid_b !== 1'b0) begin mismatched++; $display("FAIL c003_valid_after_hs got %b want 0", valid_b); end
    endtask

    initial begin
        test_reset();
        test_a5f0();
        test_full_ones();
        test_back_to_back();
        test_hold_ready();
        test_reset_mid();
        test_zero_delay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
